// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-port synchronous memory: round-robin with a data-port lock.
// Grants are combinational in the request cycle; read data returns one cycle later, tagged to its owner.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic                  d_lock_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0] state;
  logic       last_d;
  logic       if_pend;
  logic       d_pend;

  // Grants are gated by reset so outputs drop asynchronously with reset_n_i.
  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    if (reset_n_i) begin
      if (state == LOCKED) begin
        if (d_req_i)       d_gnt_o  = 1'b1;
        else if (if_req_i) if_gnt_o = 1'b1;
      end else if (if_req_i && d_req_i) begin
        if (last_d) if_gnt_o = 1'b1;
        else        d_gnt_o  = 1'b1;
      end else begin
        if_gnt_o = if_req_i;
        d_gnt_o  = d_req_i;
      end
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if (d_gnt_o) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_we_o    = d_we_i;
    end else if (if_gnt_o) begin
      mem_addr_o  = if_addr_i;
    end
  end

  // A data grant decides the lock for the next cycle; an idle data port always releases it.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      if_pend <= 1'b0;
      d_pend  <= 1'b0;
    end else begin
      if (d_gnt_o)       state <= d_lock_i ? LOCKED : IDLE;
      else if (!d_req_i) state <= IDLE;
      if (if_gnt_o)      last_d <= 1'b0;
      else if (d_gnt_o)  last_d <= 1'b1;
      if_pend <= if_gnt_o;
      d_pend  <= d_gnt_o & ~d_we_i;
    end
  end

  assign if_rvalid_o = if_pend;
  assign d_rvalid_o  = d_pend;
  assign rdata_o     = (if_pend | d_pend) ? mem_rdata_i : '0;

endmodule
